// File: rtl/mux_scan_pkg.sv
// Shared definitions for mux-tree scan controllers: FSM states, default
// lane count and the bit-reverse select encoding used by the mux tree.
package mux_scan_pkg;

   localparam int N_DEFAULT = 9;
   localparam int MAX_SW    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } scan_state_t;

   // The mux tree decodes its select MSB-first from the leaf side, so the
   // select is the index with its low sw bits reversed.
   function automatic logic [MAX_SW-1:0] sel_enc(input logic [MAX_SW-1:0] idx,
                                                 input int sw);
      logic [MAX_SW-1:0] r;
      int                j;
      logic [3:0]        jj;
      r = '0;
      for (int i = 0; i < MAX_SW; i++) begin
         j  = sw - 1 - i;
         jj = 4'(j);
         if (i < sw) r[i] = idx[jj];
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_sel_enc.sv
// Index-to-select encoder for a bit-reversed N:1 mux tree.
module mux_sel_enc
   import mux_scan_pkg::*;
#(
   parameter int SW = 4
) (
   input  logic [SW-1:0] idx,
   output logic [SW-1:0] s
);

   logic [MAX_SW-1:0] wide;

   assign wide = sel_enc(MAX_SW'(idx), SW);
   assign s    = wide[SW-1:0];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans every input of an external N:1 mux once per start request and
// presents all captured lanes together under a valid/ready handshake.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [$clog2(N)-1:0]  s,
   input  logic [W-1:0]          mux_o,
   output logic                  busy,
   output logic [N*W-1:0]        data_out,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int SW = $clog2(N);
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   scan_state_t   state_reg, state_next;
   logic [SW-1:0] idx_reg, idx_next;
   logic [SW-1:0] s_reg, s_next;
   logic          busy_reg, valid_reg;
   logic [W-1:0]  lane_reg [N];

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SCAN;
               idx_next   = '0;
            end
         end
         SCAN: begin
            // Last lane: park the select on code 0 so no unused code is driven.
            if (idx_reg == LAST) begin
               state_next = HOLD;
               idx_next   = '0;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         HOLD: begin
            if (out_ready) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   mux_sel_enc #(
      .SW (SW)
   ) u_enc (
      .idx (idx_next),
      .s   (s_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         s_reg     <= '0;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         s_reg     <= s_next;
         busy_reg  <= (state_next == SCAN);
         valid_reg <= (state_next == HOLD);
      end
   end

   // One capture register per lane; each loads only when the scan points at it.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lane_reg[gi] <= '0;
         end else if (state_reg == SCAN && idx_reg == SW'(gi)) begin
            lane_reg[gi] <= mux_o;
         end
      end
      assign data_out[gi*W +: W] = lane_reg[gi];
   end

   assign s         = s_reg;
   assign busy      = busy_reg;
   assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: a 1-bit-lane and a 4-bit-lane controller, each driving a
// behavioural bit-reversed 9:1 mux, run through scan/handshake/reset steps.
module tb_mux_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        out_ready;
   logic [8:0]  i9;

   logic [3:0]  s9, s4;
   logic        mux9;
   logic [3:0]  mux4;
   logic        busy9, busy4, valid9, valid4;
   logic [8:0]  data9;
   logic [35:0] data4;
   logic        bad9, bad4;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] s_exp [9];

   mux_scan_ctrl #(.N(9), .W(1)) dut9 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s         (s9),
      .mux_o     (mux9),
      .busy      (busy9),
      .data_out  (data9),
      .out_valid (valid9),
      .out_ready (out_ready)
   );

   mux_scan_ctrl #(.N(9), .W(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s         (s4),
      .mux_o     (mux4),
      .busy      (busy4),
      .data_out  (data4),
      .out_valid (valid4),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mux tree: s[0] is the index MSB.
   function automatic logic [3:0] tree_index(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   always_comb begin
      mux9 = 1'bx;
      if (tree_index(s9) < 4'd9) mux9 = i9[tree_index(s9)];
      mux4 = tree_index(s4);
   end

   initial begin
      bad9 = 1'b0;
      bad4 = 1'b0;
   end
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (tree_index(s9) >= 4'd9) bad9 = 1'b1;
         if (tree_index(s4) >= 4'd9) bad4 = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      s_exp[0] = 4'b0000; s_exp[1] = 4'b1000; s_exp[2] = 4'b0100;
      s_exp[3] = 4'b1100; s_exp[4] = 4'b0010; s_exp[5] = 4'b1010;
      s_exp[6] = 4'b0110; s_exp[7] = 4'b1110; s_exp[8] = 4'b0001;

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; i9 = 9'b1_0110_1001;
      @(negedge clk);
      @(negedge clk);
      chk("rst_s", s9, 4'h0);
      chk("rst_busy", busy9, 1'b0);
      chk("rst_valid", valid9, 1'b0);
      chk("rst_data9", data9, 9'h0);
      chk("rst_data4", data4, 36'h0);
      rst_n = 1'b1;
      step();
      $display("step reset: s=%b busy=%b valid=%b", s9, busy9, valid9);

      // Basic scan, both lane widths in parallel
      start = 1'b1;
      step();
      start = 1'b0;
      chk("scan_s0", s9, s_exp[0]);
      chk("scan_busy", busy9, 1'b1);
      for (int k = 1; k < 9; k++) begin
         step();
         chk($sformatf("scan_s%0d", k), s9, s_exp[k]);
         chk($sformatf("scan_s4_%0d", k), s4, s_exp[k]);
         chk($sformatf("scan_novalid%0d", k), valid9, 1'b0);
      end
      step();
      chk("done_valid9", valid9, 1'b1);
      chk("done_valid4", valid4, 1'b1);
      chk("done_busy", busy9, 1'b0);
      chk("done_s_parked", s9, 4'h0);
      chk("done_data9", data9, 9'h169);
      chk("done_data4", data4, 36'h876543210);
      $display("step basic scan: data9=%h data4=%h", data9, data4);

      // Backpressure
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_valid", valid9, 1'b1);
         chk("bp_data", data9, 9'h169);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hs_valid", valid9, 1'b0);
      chk("hs_busy", busy9, 1'b0);
      step();
      chk("idle_keep9", data9, 9'h169);
      chk("idle_keep4", data4, 36'h876543210);
      $display("step backpressure: valid=%b data9=%h", valid9, data9);

      // Start held through SCAN and HOLD, including the handshake edge
      i9 = 9'h0A5;
      start = 1'b1;
      step();
      chk("hold_start_busy", busy9, 1'b1);
      for (int k = 1; k < 9; k++) step();
      chk("hold_start_novalid", valid9, 1'b0);
      step();
      chk("hold_start_valid", valid9, 1'b1);
      chk("hold_start_data", data9, 9'h0A5);
      step();
      step();
      chk("hold_ignore_busy", busy9, 1'b0);
      chk("hold_ignore_valid", valid9, 1'b1);
      out_ready = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      chk("hs_start_busy", busy9, 1'b0);
      chk("hs_start_valid", valid9, 1'b0);
      for (int k = 0; k < 3; k++) step();
      chk("no_rescan_busy", busy9, 1'b0);
      chk("no_rescan_data", data9, 9'h0A5);
      $display("step start held: busy=%b data9=%h", busy9, data9);

      // Second scan from IDLE, aborted by reset after 4 lanes
      i9 = 9'h00F;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rescan_busy", busy9, 1'b1);
      for (int k = 0; k < 4; k++) step();
      chk("mid_s", s9, 4'b0010);
      chk("mid_data", data9, 9'h0AF);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_s", s9, 4'h0);
      chk("abort_busy", busy9, 1'b0);
      chk("abort_valid", valid9, 1'b0);
      chk("abort_data9", data9, 9'h0);
      chk("abort_data4", data4, 36'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", busy9, 1'b0);
      $display("step mid-scan reset: s=%b busy=%b data9=%h", s9, busy9, data9);

      // Recovery scan
      i9 = 9'h1FF;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k < 9; k++) step();
      chk("recov_novalid", valid9, 1'b0);
      step();
      chk("recov_valid", valid9, 1'b1);
      chk("recov_data9", data9, 9'h1FF);
      chk("recov_data4", data4, 36'h876543210);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("recov_hs", valid4, 1'b0);
      $display("step recovery: data9=%h data4=%h", data9, data4);

      chk("sel_range9", bad9, 1'b0);
      chk("sel_range4", bad4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
